// File: rtl/game_state_ctrl_pkg.sv
// Shared encodings and widths for the Frogger game sequencer.
// Consumed by the sequencer, its interface and the downstream game/lives logic.
package game_state_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int LIVES_W   = 2;
  localparam int SCORE_W   = 7;
  localparam int LEVEL_W   = 3;
  localparam int FRAME_W   = 8;
  localparam int GOAL_W    = 8;
  localparam int Y_W       = 6;
  localparam int SCORE_MAX = 99;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_HIT       = 3'd2,
    ST_P1_WINS   = 3'd3,
    ST_GAME_OVER = 3'd4,
    ST_CLEANUP   = 3'd5
  } state_t;

  // Two-digit display: the score never wraps past 99.
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Game sequencer signal bundle: frame/collision/frog inputs and play-state outputs.
// slave = the sequencer itself, master = the datapath that feeds and consumes it.
interface game_state_ctrl_if;
  import game_state_ctrl_pkg::*;

  logic               i_Game_Start;
  logic               i_VSync;
  logic               i_Collided;
  logic [Y_W-1:0]     i_Frogger_Y;
  logic [STATE_W-1:0] o_State;
  logic               o_Game_Active;
  logic               o_Respawn;
  logic [LIVES_W-1:0] o_Lives;
  logic [SCORE_W-1:0] o_Score;
  logic [LEVEL_W-1:0] o_Level;

  modport master (
    output i_Game_Start, i_VSync, i_Collided, i_Frogger_Y,
    input  o_State, o_Game_Active, o_Respawn, o_Lives, o_Score, o_Level
  );

  modport slave (
    input  i_Game_Start, i_VSync, i_Collided, i_Frogger_Y,
    output o_State, o_Game_Active, o_Respawn, o_Lives, o_Score, o_Level
  );

endinterface

// File: rtl/game_state_ctrl_edge_detect.sv
// Rising-edge detector against a registered previous sample.
// RESET_VAL=1 suppresses an edge for a level already high when reset releases.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_Sig;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign o_Rise = i_Sig & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger play sequencer: owns state, lives, score, level and respawn timing.
// state      | meaning
// IDLE       | waiting for start press
// RUNNING    | play active, collisions and goals scored
// HIT        | frog frozen for c_RESPAWN_FRAMES frame ticks
// P1_WINS    | score reached c_WIN_SCORE, counters held
// GAME_OVER  | lives exhausted, counters held
// CLEANUP    | one cycle: clear counters, reload lives, respawn
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int c_MAX_LIVES      = 3,
  parameter int c_WIN_SCORE      = 10,
  parameter int c_PTS_PER_LEVEL  = 2,
  parameter int c_MAX_LEVEL      = 7,
  parameter int c_GOAL_ROW       = 0,
  parameter int c_RESPAWN_FRAMES = 60
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  game_state_ctrl_if.slave bus
);

  logic start_rise;
  logic coll_rise;
  logic goal_rise;
  logic tick_rise;
  logic at_goal;

  assign at_goal = (bus.i_Frogger_Y == Y_W'(c_GOAL_ROW));

  edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Sig(bus.i_Game_Start), .o_Rise(start_rise)
  );
  edge_detect #(.RESET_VAL(1'b1)) u_coll_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Sig(bus.i_Collided), .o_Rise(coll_rise)
  );
  edge_detect #(.RESET_VAL(1'b1)) u_goal_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Sig(at_goal), .o_Rise(goal_rise)
  );
  edge_detect #(.RESET_VAL(1'b0)) u_vsync_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Sig(bus.i_VSync), .o_Rise(tick_rise)
  );

  state_t             state_q,     state_d;
  logic [LIVES_W-1:0] lives_q,     lives_d;
  logic [SCORE_W-1:0] score_q,     score_d;
  logic [LEVEL_W-1:0] level_q,     level_d;
  logic [GOAL_W-1:0]  goal_cnt_q,  goal_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               respawn_q,   respawn_d;
  logic               active_q,    active_d;

  logic [SCORE_W-1:0] score_inc;
  logic [GOAL_W-1:0]  goal_inc;
  logic [FRAME_W-1:0] frame_inc;

  assign score_inc = score_sat_inc(score_q);
  assign goal_inc  = goal_cnt_q + GOAL_W'(1);
  assign frame_inc = frame_cnt_q + FRAME_W'(1);

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    level_d     = level_q;
    goal_cnt_d  = goal_cnt_q;
    frame_cnt_d = frame_cnt_q;
    respawn_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_RUNNING;
          lives_d    = LIVES_W'(c_MAX_LIVES);
          score_d    = '0;
          level_d    = '0;
          goal_cnt_d = '0;
          respawn_d  = 1'b1;
        end
      end

      ST_RUNNING: begin
        // A collision in the same cycle as a goal discards the goal.
        if (coll_rise) begin
          lives_d     = lives_q - LIVES_W'(1);
          frame_cnt_d = '0;
          state_d     = (lives_q == LIVES_W'(1)) ? ST_GAME_OVER : ST_HIT;
        end else if (goal_rise) begin
          score_d = score_inc;
          if (goal_inc >= GOAL_W'(c_PTS_PER_LEVEL)) begin
            goal_cnt_d = '0;
            if (level_q < LEVEL_W'(c_MAX_LEVEL)) begin
              level_d = level_q + LEVEL_W'(1);
            end
          end else begin
            goal_cnt_d = goal_inc;
          end
          if (score_inc >= SCORE_W'(c_WIN_SCORE)) begin
            state_d = ST_P1_WINS;
          end else begin
            respawn_d = 1'b1;
          end
        end
      end

      ST_HIT: begin
        if (tick_rise) begin
          frame_cnt_d = frame_inc;
          if (frame_inc == FRAME_W'(c_RESPAWN_FRAMES)) begin
            state_d   = ST_RUNNING;
            respawn_d = 1'b1;
          end
        end
      end

      ST_P1_WINS, ST_GAME_OVER: begin
        if (start_rise) begin
          state_d = ST_CLEANUP;
        end
      end

      ST_CLEANUP: begin
        state_d     = ST_IDLE;
        lives_d     = LIVES_W'(c_MAX_LIVES);
        score_d     = '0;
        level_d     = '0;
        goal_cnt_d  = '0;
        frame_cnt_d = '0;
        respawn_d   = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        lives_d     = LIVES_W'(c_MAX_LIVES);
        score_d     = '0;
        level_d     = '0;
        goal_cnt_d  = '0;
        frame_cnt_d = '0;
        respawn_d   = 1'b0;
      end
    endcase

    active_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_W'(c_MAX_LIVES);
      score_q     <= '0;
      level_q     <= '0;
      goal_cnt_q  <= '0;
      frame_cnt_q <= '0;
      respawn_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      level_q     <= level_d;
      goal_cnt_q  <= goal_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      respawn_q   <= respawn_d;
      active_q    <= active_d;
    end
  end

  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = active_q;
  assign bus.o_Respawn     = respawn_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Score       = score_q;
  assign bus.o_Level       = level_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized bench for game_state_ctrl against a game-rules reference model.
module tb_game_state_ctrl;

  localparam int MAX_LIVES = 3;
  localparam int WIN_SCORE = 10;
  localparam int PTS_LVL   = 2;
  localparam int MAX_LEVEL = 7;
  localparam int GOAL_ROW  = 0;
  localparam int RESP_FRM  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_state_ctrl_if gif();

  game_state_ctrl #(
    .c_MAX_LIVES(MAX_LIVES), .c_WIN_SCORE(WIN_SCORE), .c_PTS_PER_LEVEL(PTS_LVL),
    .c_MAX_LEVEL(MAX_LEVEL), .c_GOAL_ROW(GOAL_ROW), .c_RESPAWN_FRAMES(RESP_FRM)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus(gif)
  );

  // Reference model: game named by the rules, states as plain numbers.
  int m_state, m_lives, m_score, m_level, m_goals, m_frames;
  int m_resp, m_active;
  int p_start, p_coll, p_goal, p_vs;
  int vs_left;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    int e_start, e_coll, e_goal, e_tick, g;
    g = (int'(gif.i_Frogger_Y) == GOAL_ROW) ? 1 : 0;
    if (rst) begin
      m_state = 0; m_lives = MAX_LIVES; m_score = 0; m_level = 0;
      m_goals = 0; m_frames = 0; m_resp = 0; m_active = 0;
      p_start = 1; p_coll = 1; p_goal = 1; p_vs = 0;
      return;
    end
    e_start = (gif.i_Game_Start && !p_start) ? 1 : 0;
    e_coll  = (gif.i_Collided && !p_coll) ? 1 : 0;
    e_goal  = (g == 1 && p_goal == 0) ? 1 : 0;
    e_tick  = (gif.i_VSync && !p_vs) ? 1 : 0;
    p_start = int'(gif.i_Game_Start); p_coll = int'(gif.i_Collided);
    p_goal = g; p_vs = int'(gif.i_VSync);
    m_resp = 0;
    case (m_state)
      0: if (e_start != 0) begin
        m_lives = MAX_LIVES; m_score = 0; m_level = 0; m_goals = 0;
        m_resp = 1; m_state = 1;
      end
      1: if (e_coll != 0) begin
        m_lives--; m_frames = 0;
        m_state = (m_lives == 0) ? 4 : 2;
      end else if (e_goal != 0) begin
        m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
        m_goals++;
        if (m_goals >= PTS_LVL) begin
          m_goals = 0;
          m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
        end
        if (m_score >= WIN_SCORE) m_state = 3;
        else m_resp = 1;
      end
      2: if (e_tick != 0) begin
        m_frames++;
        if (m_frames == RESP_FRM) begin m_resp = 1; m_state = 1; end
      end
      3, 4: if (e_start != 0) m_state = 5;
      default: begin
        m_score = 0; m_level = 0; m_goals = 0; m_frames = 0;
        m_lives = MAX_LIVES; m_resp = 1; m_state = 0;
      end
    endcase
    m_active = (m_state == 1) ? 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("state",   int'(gif.o_State),       m_state);
    chk("active",  int'(gif.o_Game_Active), m_active);
    chk("respawn", int'(gif.o_Respawn),     m_resp);
    chk("lives",   int'(gif.o_Lives),       m_lives);
    chk("score",   int'(gif.o_Score),       m_score);
    chk("level",   int'(gif.o_Level),       m_level);
    vs_left--;
    if (vs_left <= 0) begin
      gif.i_VSync = ~gif.i_VSync;
      vs_left = int'($urandom_range(1, 3));
    end
  endtask

  // mode 0: goal-heavy, 1: collision-heavy, 2: mixed with forced coincident edges
  task automatic drive_play(input int mode);
    int r, goal_pct, coll_pct;
    goal_pct = (mode == 0) ? 20 : (mode == 1) ? 2 : 10;
    coll_pct = (mode == 0) ? 1  : (mode == 1) ? 15 : 5;
    r = int'($urandom_range(0, 99));
    if (mode == 2 && r < 6 && gif.i_Collided == 1'b0 && int'(gif.i_Frogger_Y) != GOAL_ROW) begin
      gif.i_Collided  = 1'b1;
      gif.i_Frogger_Y = 6'(GOAL_ROW);
      return;
    end
    if (r < goal_pct) gif.i_Frogger_Y = 6'(GOAL_ROW);
    else if (r < goal_pct + 30) gif.i_Frogger_Y = 6'($urandom_range(1, 63));
    gif.i_Collided = (int'($urandom_range(0, 99)) < coll_pct) ? 1'b1 : 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int aborted, rst_at, hold;
    gif.i_Game_Start = 1'b1;
    gif.i_VSync      = 1'b0;
    gif.i_Collided   = 1'b0;
    gif.i_Frogger_Y  = 6'd12;
    vs_left = 2;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (4) cycle();            // start held through reset: no game
    gif.i_Game_Start = 1'b0;
    repeat (2) cycle();

    for (int g = 0; g < 12; g++) begin
      aborted = 0;
      rst_at  = (g == 7) ? int'($urandom_range(5, 150)) : -1;
      gif.i_Collided  = 1'b0;
      gif.i_Frogger_Y = 6'd12;
      gif.i_Game_Start = 1'b1;
      hold = int'($urandom_range(1, 4));
      repeat (hold) cycle();
      gif.i_Game_Start = 1'b0;
      for (int c = 0; c < 5000; c++) begin
        if (m_state == 3 || m_state == 4) break;
        drive_play(g % 3);
        if (((g == 4 || g == 9) && m_state == 2 && m_frames == 30) || c == rst_at) begin
          rst = 1'b1;
          cycle();
          rst = 1'b0;
          aborted = 1;
          break;
        end
        cycle();
      end
      gif.i_Collided  = 1'b0;
      gif.i_Frogger_Y = 6'd12;
      if (aborted == 0) begin
        chk("game_end", (gif.o_State == 3'd3 || gif.o_State == 3'd4) ? 1 : 0, 1);
        repeat (2) cycle();
        gif.i_Game_Start = 1'b1;
        cycle();
        gif.i_Game_Start = 1'b0;
        repeat (3) cycle();
      end else begin
        repeat (3) cycle();
      end
      chk("back_idle", int'(gif.o_State), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer for the Frogger design. It owns the play state machine, the lives count, the score and the difficulty level, and it tells the rest of the datapath when play is active and when to put the frog back at the start. It consumes the collision flag, the frog row and the VSync frame timing, and it drives the frog controller, the car controllers, the lives LEDs and the score display.

## Interface
Parameters:
- c_MAX_LIVES, 3: lives loaded at game start (1..3).
- c_WIN_SCORE, 10: score that ends the game with a win (1..99).
- c_PTS_PER_LEVEL, 2: goals needed per level increment.
- c_MAX_LEVEL, 7: level saturation value (≤7).
- c_GOAL_ROW, 0: frog tile row that counts as a goal.
- c_RESPAWN_FRAMES, 60: frozen frames after a hit (1..255).

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Rst  in  1  synchronous reset, active-high.
- i_Game_Start  in  1  start button level.
- i_VSync  in  1  VSync from Sync_To_Count; a rising edge is one frame tick.
- i_Collided  in  1  collision level from frogger_collisions.
- i_Frogger_Y  in  6  current frog tile row.
- o_State  out  3  current state encoding.
- o_Game_Active  out  1  high only in RUNNING.
- o_Respawn  out  1  one-cycle pulse that returns the frog to its start tile.
- o_Lives  out  2  remaining lives.
- o_Score  out  7  score, 0..99.
- o_Level  out  3  difficulty level for car speed selection.

## Operation
- All inputs are edge-detected against a registered copy.
  - The start edge fires when i_Game_Start=1 and its previous sample was 0. The previous-sample register resets to 1, so a button held through reset does not start a game.
  - The collision edge uses the same rule on i_Collided.
  - The goal edge fires on a 0→1 transition of (i_Frogger_Y == c_GOAL_ROW).
  - The frame tick fires on an i_VSync 0→1 transition.
- States:
  - IDLE (0): on a start edge, load lives=c_MAX_LIVES, score=0, level=0, pulse o_Respawn, go to RUNNING.
  - RUNNING (1): o_Game_Active=1.
    - Collision edge: lives decrements. If lives was 1, set lives=0 and go to GAME_OVER; otherwise go to HIT.
    - Goal edge, with no collision edge in the same cycle:
      - score increments, saturating at 99.
      - The per-level goal counter increments. When it reaches c_PTS_PER_LEVEL it clears to 0 and level increments, saturating at c_MAX_LEVEL.
      - If the new score is ≥ c_WIN_SCORE, go to P1_WINS. Otherwise pulse o_Respawn and stay in RUNNING.
    - If a collision edge and a goal edge occur in the same cycle, the collision wins and the goal is discarded.
  - HIT (2): o_Game_Active=0.
    - The frame counter loads 0 on entry and counts frame ticks.
    - When the count reaches c_RESPAWN_FRAMES, pulse o_Respawn and return to RUNNING.
    - Collision and goal edges are ignored.
  - P1_WINS (3) / GAME_OVER (4): hold all counters. A start edge moves to CLEANUP.
  - CLEANUP (5): one cycle. Clear score, level and goal counter, reload lives, pulse o_Respawn, go to IDLE.
- Encodings 6 and 7 are illegal. The next clock moves to IDLE with the reset values.
- Reset values: state=IDLE, o_Game_Active=0, o_Respawn=0, o_Lives=c_MAX_LIVES, o_Score=0, o_Level=0, frame counter=0, goal counter=0.
- i_Rst asserted mid-game (any state, including HIT mid-count) returns to the reset values on the next edge. No pending respawn survives the reset.

## Timing
- All outputs are registered. A qualifying input edge sampled at clock edge N is reflected in every output after edge N (1-cycle latency). A start, collision or goal input held high produces exactly one event.
- o_Respawn is exactly one cycle wide and is asserted in the same cycle the new state becomes visible.
- HIT duration is c_RESPAWN_FRAMES frame ticks. The tick counting starts with the first tick after entry; a tick in the entry cycle itself is not counted.
- The goal edge requires the frog row to leave and re-enter c_GOAL_ROW. After respawn the frog is at its start row, which re-arms the detector.

## Structure
- The shared package holds the state encodings (IDLE=0, RUNNING=1, HIT=2, P1_WINS=3, GAME_OVER=4, CLEANUP=5) and the 3-bit state width. frogger_game and lives_counter consume them.
- One sub-module, edge_detect, parameterised by reset value. It is instanced four times: start, collision, goal and VSync.
- The FSM, lives counter, score, level and frame counters stay in the top. There is no divider; level advances through the goal counter.

## Test plan
- Reset, then start held high across reset release → state stays IDLE. Release, then press → RUNNING after 1 cycle, o_Respawn pulses once, lives=3.
- In RUNNING, three collision edges separated by HIT intervals → lives 2 then 1, HIT lasting 60 frames each time, then GAME_OVER with lives=0 and o_Game_Active=0.
- Ten goal edges (i_Frogger_Y 12→0 each) → score 1..10, level 5, one o_Respawn per goal except the tenth, state P1_WINS.
- Collision and goal edges in the same cycle with lives=2 → HIT, lives=1, score unchanged.
- Assert i_Rst at frame 30 of HIT → IDLE, lives=3, no o_Respawn pulse.
- In GAME_OVER, press start → CLEANUP for one cycle with o_Respawn pulsed, then IDLE, score=0.
